rpmem_target: RTL and testbench
===============================

# rpmem_target

SPI responder that terminates the 0x02/0x03 command protocol inside the FPGA and bridges each transaction onto the internal valid/ready memory bus as a bus initiator. An external SPI initiator drives `ss`, `sclk` and `mosi`. The block returns read data on `miso` and paces reads with `hold`. It gives an external controller 32-bit access to on-chip memory and peripherals through the same 4-wire link plus `hold`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers on `ss`, `sclk` and `mosi`; minimum 2.
- `ADDR_HI`, default 8'h00: fixed upper byte of `mem_addr`.
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `ss`  in  1  SPI select, active-low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, asynchronous to `clk`, idles low (mode 0).
- `mosi`  in  1  SPI data from the initiator, MSB first.
- `miso`  out  1  SPI data to the initiator, MSB first; reset 0.
- `hold`  out  1  high while read data is not yet available; reset 0.
- `mem_valid`  out  1  bus request; reset 0.
- `mem_write`  out  1  1 = write, 0 = read; reset 0.
- `mem_addr`  out  32  {ADDR_HI, addr24}; reset 0.
- `mem_wdata`  out  32  write data; reset 0.
- `mem_rdata`  in  32  read data, valid while `mem_ready` is high.
- `mem_ready`  in  1  bus completion, one-cycle pulse.
- `bad_cmd`  out  1  one-cycle pulse when an unknown opcode is received; reset 0.

## Operation
- Frame: `ss` falls, then 8-bit opcode, 24-bit address, then 32 data bits; `ss` rises at the end of the frame. Opcode 0x02 = write (data on `mosi`); opcode 0x03 = read (data on `miso`).
- Sampling: `mosi` is sampled on the synchronized rising `sclk` edge. `miso` is updated on the synchronized falling edge. Bit 31 of the read word is driven as soon as it is loaded.
- States:
  - IDLE: waiting for `ss` low. On `ss` low, bit counter := 0 and go to CMD.
  - CMD: shift in 8 bits. 0x02 or 0x03 goes to ADDR. Any other value pulses `bad_cmd` and goes to DROP.
  - ADDR: shift in 24 bits, then latch `mem_addr`.
    - Read: set `hold`=1 and go to RDREQ.
    - Write: go to WRDATA.
  - RDREQ: assert `mem_valid` with `mem_write`=0. On `mem_ready`: latch `mem_rdata` into the shift register, drive `miso` = bit 31, clear `hold`, go to RDDATA.
  - RDDATA: shift out 32 bits, then go to DROP.
  - WRDATA: shift in 32 bits, latch `mem_wdata`, go to WRREQ.
  - WRREQ: assert `mem_valid` with `mem_write`=1 until `mem_ready`, then go to DROP.
  - DROP: ignore `sclk`, drive `miso`=0, wait for `ss` high, then go to IDLE.
- Bus rules:
  - At most one request outstanding.
  - `mem_valid`, `mem_write`, `mem_addr` and `mem_wdata` stay stable from assertion until the cycle `mem_ready` is sampled high. `mem_valid` deasserts the following cycle.
- Abort: `ss` going high in CMD, ADDR, WRDATA or RDDATA returns to IDLE on the next cycle. Partial writes are never issued.
- Abort while `mem_valid` is high (RDREQ/WRREQ): the request is held until `mem_ready`. Read data is discarded and `hold` is cleared. Then go to IDLE.
- New frame during a pending request: `ss` falling is not accepted until the request completes. Initiators must keep ≥100 `clk` cycles between `ss` falling and the first `sclk` edge.
- Extra `sclk` edges beyond 64 in a frame are ignored (DROP).

## Timing
- Synchronizer latency is `SYNC_STAGES` cycles; edge detection adds 1 cycle.
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+3 `clk` cycles.
- `hold` rises ≤ `SYNC_STAGES`+2 cycles after the 32nd `sclk` rising edge of a read frame. Initiators must wait ≥ 16 `clk` cycles after that edge before sampling `hold`.
- `mem_valid` rises 1 cycle after entering RDREQ or WRREQ.
- `hold` falls and `miso` = rdata[31] in the cycle after `mem_ready` is sampled.
- Write commit: `mem_valid` rises `SYNC_STAGES`+3 cycles after the 64th rising `sclk` edge.
- Asynchronous reset: all state returns to IDLE and all outputs take their reset values immediately, including mid-request. The bus fabric must tolerate `mem_valid` dropping on reset.

## Structure
- Shared package `rpmem_pkg`:
  - opcode constants OP_WRITE=8'h02, OP_READ=8'h03
  - state enum
  - field widths: CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32
- Sub-module `rpmem_sync`: parameterized `SYNC_STAGES` flip-flop synchronizer, instantiated once per input (`ss`, `sclk`, `mosi`). The top level keeps the FSM, 32-bit shift register and 6-bit bit counter.

## Test plan
- Write: frame 0x02, addr 0x001234, data 0xDEADBEEF -> one bus write, `mem_addr`=0x00001234, `mem_wdata`=0xDEADBEEF, `hold` stays 0.
- Read: frame 0x03, addr 0x000010; memory returns 0xCAFEF00D after 3 cycles -> `hold` 1 then 0; `miso` shifts out 0xCAFEF00D MSB first.
- Slow read: `mem_ready` delayed 500 cycles -> `hold` stays high for the whole wait; no `miso` change until data is latched; returned data is correct.
- Bad opcode: 0x9F -> `bad_cmd` pulses once; no `mem_valid`; `miso`=0 until `ss` rises; the next valid frame works.
- Abort: `ss` raised after 16 address bits, then after 20 data bits of a write -> no bus request in either case; the next frame decodes correctly.
- Reset mid-read: `resetn` low while `mem_valid`=1 -> all outputs return to reset values asynchronously; after release, a read to 0x000004 completes normally.

Source files
------------

// File: rtl/rpmem_pkg.sv
// Shared definitions for the rpmem SPI-to-memory-bus bridge: opcode values,
// frame field widths and the responder FSM state type.
package rpmem_pkg;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned DATA_BITS = 32;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRdReq,
    StRdData,
    StWrData,
    StWrReq,
    StDrop
  } state_e;

endpackage

// File: rtl/rpmem_sync.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   d           : asynchronous input
//   q           : synchronized output, SYNC_STAGES cycles of latency
// RESET_VAL lets the select line come out of reset in its inactive (high) state.
module rpmem_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rpmem_target.sv
// SPI (mode 0) responder that decodes 0x02 write / 0x03 read frames and issues
// one 32-bit transaction per frame on the internal valid/ready memory bus.
// Ports:
//   clk, resetn          : system clock, asynchronous active-low reset
//   ss, sclk, mosi       : SPI inputs, asynchronous to clk
//   miso, hold           : SPI read data and read-pacing flag
//   mem_valid/write/addr/wdata, mem_rdata/ready : memory bus initiator side
//   bad_cmd              : one-cycle pulse on an unknown opcode
module rpmem_target
  import rpmem_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ADDR_HI     = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ss,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        hold,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bad_cmd
);

  localparam logic [5:0] LastCmdBit  = 6'(CMD_BITS - 1);
  localparam logic [5:0] LastAddrBit = 6'(CMD_BITS + ADDR_BITS - 1);
  localparam logic [5:0] LastDataBit = 6'(CMD_BITS + ADDR_BITS + DATA_BITS - 1);
  localparam logic [5:0] FirstRdBit  = 6'(CMD_BITS + ADDR_BITS);

  logic w_ss, w_sclk, w_mosi;

  rpmem_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk    (clk),
    .resetn (resetn),
    .d      (ss),
    .q      (w_ss)
  );

  rpmem_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .resetn (resetn),
    .d      (sclk),
    .q      (w_sclk)
  );

  rpmem_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .resetn (resetn),
    .d      (mosi),
    .q      (w_mosi)
  );

  // Registered edge pulses; mosi is delayed alongside so it lines up with r_rise.
  logic r_sclk_prev, r_rise, r_fall, r_mosi;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_rise      <= w_sclk & ~r_sclk_prev;
      r_fall      <= ~w_sclk & r_sclk_prev;
      r_mosi      <= w_mosi;
    end
  end

  state_e      r_state;
  logic [31:0] r_shift;
  logic [5:0]  r_cnt;       // rising sclk edges seen in this frame
  logic        r_is_read;
  logic        r_abort;     // ss rose while a bus request was pending
  logic        r_miso, r_hold, r_mem_valid, r_mem_write, r_bad_cmd;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [31:0] w_shift_next;

  assign w_shift_next = {r_shift[30:0], r_mosi};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_is_read   <= 1'b0;
      r_abort     <= 1'b0;
      r_miso      <= 1'b0;
      r_hold      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_bad_cmd   <= 1'b0;
    end else begin
      r_bad_cmd <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_abort <= 1'b0;
          r_miso  <= 1'b0;
          if (!w_ss) begin
            r_cnt   <= '0;
            r_state <= StCmd;
          end
        end
        StCmd: begin
          if (w_ss) begin
            r_state <= StIdle;
          end else if (r_rise) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == LastCmdBit) begin
              if (w_shift_next[7:0] == OP_READ || w_shift_next[7:0] == OP_WRITE) begin
                r_is_read <= (w_shift_next[7:0] == OP_READ);
                r_state   <= StAddr;
              end else begin
                r_bad_cmd <= 1'b1;
                r_state   <= StDrop;
              end
            end
          end
        end
        StAddr: begin
          if (w_ss) begin
            r_state <= StIdle;
          end else if (r_rise) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == LastAddrBit) begin
              r_mem_addr  <= {ADDR_HI, w_shift_next[ADDR_BITS-1:0]};
              r_mem_write <= ~r_is_read;
              if (r_is_read) begin
                r_hold  <= 1'b1;
                r_state <= StRdReq;
              end else begin
                r_state <= StWrData;
              end
            end
          end
        end
        StRdReq: begin
          if (w_ss) r_abort <= 1'b1;
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
          end else if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_hold      <= 1'b0;
            if (r_abort || w_ss) begin
              r_state <= StIdle;
            end else begin
              r_shift <= mem_rdata;
              r_miso  <= mem_rdata[31];
              r_state <= StRdData;
            end
          end
        end
        StRdData: begin
          if (w_ss) begin
            r_miso  <= 1'b0;
            r_state <= StIdle;
          end else if (r_rise) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == LastDataBit) begin
              r_miso  <= 1'b0;
              r_state <= StDrop;
            end
          end else if (r_fall && r_cnt != FirstRdBit) begin
            // The fall of the last address bit may land here; bit 31 must survive it.
            r_shift <= {r_shift[30:0], 1'b0};
            r_miso  <= r_shift[30];
          end
        end
        StWrData: begin
          if (w_ss) begin
            r_state <= StIdle;
          end else if (r_rise) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == LastDataBit) begin
              r_mem_wdata <= w_shift_next;
              r_state     <= StWrReq;
            end
          end
        end
        StWrReq: begin
          if (w_ss) r_abort <= 1'b1;
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
          end else if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= (r_abort || w_ss) ? StIdle : StDrop;
          end
        end
        StDrop: begin
          r_miso <= 1'b0;
          if (w_ss) r_state <= StIdle;
        end
      endcase
    end
  end

  assign miso      = r_miso;
  assign hold      = r_hold;
  assign mem_valid = r_mem_valid;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bad_cmd   = r_bad_cmd;

endmodule

// File: tb/tb_rpmem_target.sv
// Directed bench for rpmem_target: SPI initiator driver, latency-configurable
// memory responder and event counters used for the expected-value checks.
module tb_rpmem_target;

  logic        clk = 1'b0;
  logic        resetn, ss, sclk, mosi;
  logic        miso, hold, mem_valid, mem_write, bad_cmd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  rpmem_target #(.SYNC_STAGES(2), .ADDR_HI(8'h00)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ss        (ss),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .hold      (hold),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bad_cmd   (bad_cmd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned lat = 3;
  logic [31:0] rd_word = '0;
  int unsigned resp_cnt;
  int          wr_cnt = 0, rd_cnt = 0, req_cnt = 0, bad_cnt = 0;
  int          hold_cyc = 0, miso_hold_cyc = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        last_write = 1'b0;
  logic        valid_prev = 1'b0;

  // Memory responder: one-cycle ready pulse `lat` cycles after a request appears.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      resp_cnt  <= 0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_valid && !mem_ready) begin
        if (resp_cnt >= lat) begin
          mem_ready  <= 1'b1;
          mem_rdata  <= rd_word;
          resp_cnt   <= 0;
          last_addr  <= mem_addr;
          last_wdata <= mem_wdata;
          last_write <= mem_write;
          if (mem_write) wr_cnt <= wr_cnt + 1;
          else           rd_cnt <= rd_cnt + 1;
        end else begin
          resp_cnt <= resp_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    valid_prev <= mem_valid;
    if (mem_valid && !valid_prev) req_cnt <= req_cnt + 1;
    if (bad_cmd) bad_cnt <= bad_cnt + 1;
    if (hold) hold_cyc <= hold_cyc + 1;
    if (hold && miso) miso_hold_cyc <= miso_hold_cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] rd);
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      repeat (8) @(negedge clk);
      rd   = {rd[30:0], miso};
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    repeat (110) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_hold_low(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!hold) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [31:0] data);
    logic [31:0] d;
    frame_begin();
    spi_bits(32'h02, 8, d);
    spi_bits({8'h00, addr}, 24, d);
    spi_bits(data, 32, d);
    frame_end();
    repeat (20) @(negedge clk);
  endtask

  task automatic do_read(input logic [23:0] addr, output logic [31:0] rd, output logic ok);
    logic [31:0] d;
    frame_begin();
    spi_bits(32'h03, 8, d);
    spi_bits({8'h00, addr}, 24, d);
    repeat (16) @(negedge clk);
    wait_hold_low(ok);
    spi_bits(32'h0, 32, rd);
    frame_end();
  endtask

  initial begin
    logic [31:0] rd, rd1, rd2;
    logic        ok;
    int          w0, r0, b0, h0, m0;

    resetn = 1'b0;
    ss     = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso", 32'(miso), 0);
    check_eq("rst_hold", 32'(hold), 0);
    check_eq("rst_valid", 32'(mem_valid), 0);
    check_eq("rst_write", 32'(mem_write), 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_bad_cmd", 32'(bad_cmd), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Write
    w0 = wr_cnt; h0 = hold_cyc; r0 = req_cnt;
    do_write(24'h001234, 32'hDEADBEEF);
    check_eq("wr_count", 32'(wr_cnt - w0), 1);
    check_eq("wr_req_count", 32'(req_cnt - r0), 1);
    check_eq("wr_addr", last_addr, 32'h0000_1234);
    check_eq("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    check_eq("wr_is_write", 32'(last_write), 1);
    check_eq("wr_hold_quiet", 32'(hold_cyc - h0), 0);

    // Read, fast memory
    lat = 3; rd_word = 32'hCAFEF00D; h0 = hold_cyc;
    do_read(24'h000010, rd, ok);
    check_eq("rd_hold_release", 32'(ok), 1);
    check_eq("rd_hold_seen", 32'(hold_cyc > h0), 1);
    check_eq("rd_data", rd, 32'hCAFE_F00D);
    check_eq("rd_addr", last_addr, 32'h0000_0010);
    check_eq("rd_is_read", 32'(last_write), 0);

    // Slow read
    lat = 500; rd_word = 32'h12345678; h0 = hold_cyc; m0 = miso_hold_cyc;
    frame_begin();
    spi_bits(32'h03, 8, rd1);
    spi_bits(32'h000100, 24, rd1);
    repeat (250) @(negedge clk);
    check_eq("slow_hold_mid", 32'(hold), 1);
    check_eq("slow_valid_mid", 32'(mem_valid), 1);
    check_eq("slow_miso_mid", 32'(miso), 0);
    wait_hold_low(ok);
    check_eq("slow_hold_release", 32'(ok), 1);
    spi_bits(32'h0, 32, rd);
    frame_end();
    check_eq("slow_data", rd, 32'h1234_5678);
    check_eq("slow_hold_len", 32'(hold_cyc - h0 >= 500), 1);
    check_eq("slow_miso_quiet", 32'(miso_hold_cyc - m0), 0);

    // Bad opcode
    lat = 3; b0 = bad_cnt; r0 = req_cnt;
    frame_begin();
    spi_bits(32'h9F, 8, rd1);
    spi_bits(32'hFFFFFF, 24, rd1);
    spi_bits(32'hFFFFFFFF, 32, rd2);
    frame_end();
    check_eq("bad_pulses", 32'(bad_cnt - b0), 1);
    check_eq("bad_no_req", 32'(req_cnt - r0), 0);
    check_eq("bad_miso_a", rd1, 0);
    check_eq("bad_miso_b", rd2, 0);
    do_write(24'h000020, 32'h0BADF00D);
    check_eq("bad_next_addr", last_addr, 32'h0000_0020);
    check_eq("bad_next_wdata", last_wdata, 32'h0BAD_F00D);

    // Aborts: mid-address, then mid-write-data
    r0 = req_cnt;
    frame_begin();
    spi_bits(32'h02, 8, rd1);
    spi_bits(32'h00AB, 16, rd1);
    ss = 1'b1;
    repeat (40) @(negedge clk);
    frame_begin();
    spi_bits(32'h02, 8, rd1);
    spi_bits(32'h000055, 24, rd1);
    spi_bits(32'h000FFFFF, 20, rd1);
    ss = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_no_req", 32'(req_cnt - r0), 0);
    do_write(24'hABCDEF, 32'h55AA33CC);
    check_eq("abort_next_req", 32'(req_cnt - r0), 1);
    check_eq("abort_next_addr", last_addr, 32'h00AB_CDEF);
    check_eq("abort_next_wdata", last_wdata, 32'h55AA_33CC);

    // Reset in the middle of a pending read
    lat = 500;
    frame_begin();
    spi_bits(32'h03, 8, rd1);
    spi_bits(32'h000040, 24, rd1);
    repeat (50) @(negedge clk);
    check_eq("mid_valid", 32'(mem_valid), 1);
    check_eq("mid_hold", 32'(hold), 1);
    resetn = 1'b0;
    #1;
    check_eq("rstmid_valid", 32'(mem_valid), 0);
    check_eq("rstmid_hold", 32'(hold), 0);
    check_eq("rstmid_addr", mem_addr, 0);
    check_eq("rstmid_miso", 32'(miso), 0);
    ss = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    lat = 2; rd_word = 32'hA5A50004;
    do_read(24'h000004, rd, ok);
    check_eq("post_rst_release", 32'(ok), 1);
    check_eq("post_rst_data", rd, 32'hA5A5_0004);
    check_eq("post_rst_addr", last_addr, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
